reset_sequencer: RTL and testbench

- Sits directly downstream of the system clock/reset controller and consumes its system clock and active-low reset.
- Releases up to NUM_STAGES peripheral reset domains one at a time, in a fixed order, with a programmable gap between stages (e.g. bus fabric, then memory, then CPU, then peripherals).
- Provides a software-requested partial reset of a masked subset of stages, using a req/ack handshake.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_seq_timer.sv | 30 +++
 rtl/reset_sequencer.sv | 124 ++++++++++++
 tb/tb_reset_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_e   : FSM state encoding, also exported on state_o for debug
//   STATE_W   : width of the state field
//   cnt_width : width needed by the gap/hold counter so it can reach
//               max(stage_delay, sw_rst_hold) without wrapping
package rst_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_SW_HOLD = 2'd3
  } state_e;

  function automatic int cnt_width(input int stage_delay, input int sw_rst_hold);
    int m;
    m = (stage_delay > sw_rst_hold) ? stage_delay : sw_rst_hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable up-counter with terminal-count compare. Shared between the
// inter-stage release gap and the software reset hold time.
//   clk   : system clock
//   nrst  : synchronous active-low reset
//   clear : restart counting from zero on the next edge
//   limit : terminal count
//   done  : high while the count equals limit
module rst_seq_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/reset_sequencer.sv
// Staged peripheral reset release with a software partial-reset handshake.
//   clk_i          : system clock
//   nrst_i         : synchronous active-low reset
//   sw_rst_req_i   : software reset request (level, held until ack)
//   stage_mask_i   : stages to reset, captured when the request is accepted
//   sw_rst_ack_o   : one-cycle pulse when a software reset (or null request) completes
//   stage_rst_o    : per-stage active-high reset
//   stage_nrst_o   : per-stage active-low reset
//   all_released_o : every stage out of reset and FSM in RUN
//   state_o        : current FSM state
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_ASSERT  | one cycle after reset, all stages held
// S_RELEASE | releasing stages in order, one every STAGE_DELAY cycles
// S_RUN     | all stages released, serving software requests
// S_SW_HOLD | masked stages held for SW_RST_HOLD cycles
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int SW_RST_HOLD = 8
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic                  sw_rst_req_i,
  input  logic [NUM_STAGES-1:0] stage_mask_i,
  output logic                  sw_rst_ack_o,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic [NUM_STAGES-1:0] stage_nrst_o,
  output logic                  all_released_o,
  output logic [STATE_W-1:0]    state_o
);

  localparam int CNT_W = cnt_width(STAGE_DELAY, SW_RST_HOLD);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(SW_RST_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  state_e                  state;
  logic [IDX_W-1:0]        idx;
  logic [NUM_STAGES-1:0]   mask_q;
  logic                    tmr_clear;
  logic                    tmr_done;
  logic [CNT_W-1:0]        tmr_limit;

  // Counter only runs in RELEASE and SW_HOLD; holding it cleared elsewhere
  // guarantees it starts from zero on every entry into a timed state.
  assign tmr_clear = (state == S_ASSERT) || (state == S_RUN) || tmr_done;
  assign tmr_limit = (state == S_SW_HOLD) ? HOLD_LIM : GAP_LIM;

  rst_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk_i),
    .nrst  (nrst_i),
    .clear (tmr_clear),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state          <= S_ASSERT;
      idx            <= '0;
      mask_q         <= '0;
      stage_rst_o    <= '1;
      stage_nrst_o   <= '0;
      sw_rst_ack_o   <= 1'b0;
      all_released_o <= 1'b0;
    end else begin
      sw_rst_ack_o <= 1'b0;
      unique case (state)
        S_ASSERT: begin
          idx   <= '0;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (tmr_done) begin
            stage_rst_o[idx]  <= 1'b0;
            stage_nrst_o[idx] <= 1'b1;
            if (idx == LAST_IDX) begin
              idx            <= '0;
              all_released_o <= 1'b1;
              state          <= S_RUN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_RUN: begin
          if (sw_rst_req_i) begin
            if (|stage_mask_i) begin
              mask_q         <= stage_mask_i;
              stage_rst_o    <= stage_rst_o | stage_mask_i;
              stage_nrst_o   <= stage_nrst_o & ~stage_mask_i;
              all_released_o <= 1'b0;
              state          <= S_SW_HOLD;
            end else begin
              // Null request: acknowledge without touching any stage.
              sw_rst_ack_o <= 1'b1;
            end
          end
        end
        S_SW_HOLD: begin
          if (tmr_done) begin
            stage_rst_o    <= stage_rst_o & ~mask_q;
            stage_nrst_o   <= stage_nrst_o | mask_q;
            sw_rst_ack_o   <= 1'b1;
            all_released_o <= 1'b1;
            state          <= S_RUN;
          end
        end
        default: state <= S_ASSERT;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int NS   = 4;
  localparam int SD   = 16;
  localparam int SH   = 8;
  localparam int BOOT = 1 + NS * SD;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          req = 1'b0;
  logic [NS-1:0] mask = '0;
  logic          ack;
  logic          all_rel;
  logic [NS-1:0] srst;
  logic [NS-1:0] snrst;
  logic [1:0]    st;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES (NS),
    .STAGE_DELAY(SD),
    .SW_RST_HOLD(SH)
  ) dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .sw_rst_req_i  (req),
    .stage_mask_i  (mask),
    .sw_rst_ack_o  (ack),
    .stage_rst_o   (srst),
    .stage_nrst_o  (snrst),
    .all_released_o(all_rel),
    .state_o       (st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs are derived from the edge count since reset
  // (boot schedule in closed form) and from the absolute edge on which a
  // software hold must end.
  int            n = 0;
  bit            m_valid = 0;
  bit            in_hold = 0;
  int            hold_end = 0;
  logic [NS-1:0] hold_mask = '0;
  logic [NS-1:0] m_rst = '1;
  logic          m_ack = 0;
  logic          m_all = 0;
  logic [1:0]    m_state = 0;

  always @(posedge clk) begin
    if (!nrst) begin
      n = 0; in_hold = 0; m_rst = '1; m_ack = 0; m_all = 0; m_state = 0;
      m_valid = 1;
    end else if (m_valid) begin
      n++;
      m_ack = 0;
      if (n <= BOOT) begin
        for (int k = 0; k < NS; k++) m_rst[k] = (n < 1 + (k + 1) * SD);
        m_state = (n == BOOT) ? 2'd2 : 2'd1;
        m_all   = (n == BOOT);
      end else if (in_hold) begin
        if (n == hold_end) begin
          m_rst   = m_rst & ~hold_mask;
          m_ack   = 1; m_all = 1; in_hold = 0; m_state = 2;
        end
      end else if (req) begin
        if (mask != 0) begin
          in_hold = 1; hold_mask = mask; hold_end = n + SH;
          m_rst = m_rst | mask; m_all = 0; m_state = 3;
        end else begin
          m_ack = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NS-1:0] exp_n;
    if (m_valid) begin
      exp_n = ~m_rst;
      check("stage_rst", srst, m_rst);
      check("stage_nrst", snrst, exp_n);
      check("ack", ack, m_ack);
      check("all_released", all_rel, m_all);
      check("state", st, m_state);
    end
  end

  task automatic wait_ack(input int max_edges, output int n_edges);
    n_edges = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(negedge clk);
      if (ack) begin
        n_edges = i;
        break;
      end
    end
    if (n_edges < 0) begin
      errors++; checks++;
      $display("FAIL ack_timeout: got no ack expected ack within %0d edges", max_edges);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst"}, srst, 4'b1111);
    check({tag, "_nrst"}, snrst, 4'b0000);
    check({tag, "_ack"}, ack, 1'b0);
    check({tag, "_all"}, all_rel, 1'b0);
    check({tag, "_state"}, st, 2'd0);
  endtask

  // Releases reset and walks the boot sequence, pinning the edge offsets.
  task automatic boot_check(input string tag);
    nrst = 1'b1;
    for (int e = 1; e <= BOOT; e++) begin
      @(negedge clk);
      if (e == 1)          check({tag, "_state_e1"}, st, 2'd1);
      if (e == SD)         check({tag, "_rst_e16"}, srst, 4'b1111);
      if (e == SD + 1)     check({tag, "_rst_e17"}, srst, 4'b1110);
      if (e == 2 * SD + 1) check({tag, "_rst_e33"}, srst, 4'b1100);
      if (e == 3 * SD + 1) check({tag, "_rst_e49"}, srst, 4'b1000);
      if (e == BOOT - 1)   check({tag, "_all_e64"}, all_rel, 1'b0);
      if (e == BOOT) begin
        check({tag, "_rst_e65"}, srst, 4'b0000);
        check({tag, "_all_e65"}, all_rel, 1'b1);
        check({tag, "_state_e65"}, st, 2'd2);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    int na2;

    repeat (3) @(negedge clk);
    check_reset_state("por");
    boot_check("boot1");

    // Masked software reset of stages 0 and 2.
    repeat (2) @(negedge clk);
    req = 1'b1; mask = 4'b0101;
    @(negedge clk);
    check("sw1_rst", srst, 4'b0101);
    check("sw1_all", all_rel, 1'b0);
    check("sw1_state", st, 2'd3);
    wait_ack(40, na);
    check("sw1_hold_len", na, SH);
    check("sw1_rst_after", srst, 4'b0000);
    req = 1'b0; mask = '0;
    @(negedge clk);
    check("sw1_ack_pulse", ack, 1'b0);

    // Null request.
    repeat (3) @(negedge clk);
    req = 1'b1; mask = '0;
    @(negedge clk);
    check("null_ack", ack, 1'b1);
    check("null_rst", srst, 4'b0000);
    check("null_all", all_rel, 1'b1);
    req = 1'b0;
    @(negedge clk);
    check("null_ack_pulse", ack, 1'b0);

    // Request raised while stages are still being released.
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (29) @(negedge clk);
    req = 1'b1; mask = 4'b0110;
    wait_ack(100, na);
    check("pending_ack_edge", 29 + na, BOOT + 1 + SH);
    req = 1'b0;

    // Reset during a software hold.
    repeat (2) @(negedge clk);
    req = 1'b1; mask = 4'b1111;
    repeat (3) @(negedge clk);
    req = 1'b0; nrst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_in_hold");
    boot_check("boot2");

    // Reset during release at index 2.
    repeat (40) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (40) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_in_release");
    boot_check("boot3");

    // Request held past the ack: second reset of stage 3.
    repeat (2) @(negedge clk);
    req = 1'b1; mask = 4'b1000;
    wait_ack(40, na);
    check("rep_first_ack", na, SH + 1);
    @(negedge clk);
    check("rep_restart_state", st, 2'd3);
    check("rep_restart_rst", srst, 4'b1000);
    @(negedge clk);
    req = 1'b0;
    wait_ack(40, na2);
    check("rep_second_ack", na2 + 2, SH + 1);

    // Randomized traffic, including resets at arbitrary points.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        req = 1'b0;
        nrst = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        nrst = 1'b1;
        repeat ($urandom_range(0, 80)) @(negedge clk);
      end else begin
        req = 1'b1;
        mask = NS'($urandom);
        repeat ($urandom_range(1, 12)) @(negedge clk);
        req = 1'b0;
        mask = NS'($urandom);
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
    req = 1'b0;
    repeat (80) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
